// File: rtl/fpu_rr_scheduler_if.sv
// Bundle between the requesting FPU units, the round-robin scheduler and the shared execution slave.
// The scheduler takes the slave modport; the requesters plus the execution unit take the master side.
interface fpu_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int SELW = 2,
    parameter int DW   = 32,
    parameter int OPW  = 4
);
    logic [NREQ-1:0]     M_req;
    logic [NREQ*OPW-1:0] M_op;
    logic [NREQ*DW-1:0]  M_opa;
    logic [NREQ*DW-1:0]  M_opb;
    logic [NREQ-1:0]     M_ack;
    logic [NREQ-1:0]     M_err;
    logic [DW-1:0]       M_result;
    logic                S_req;
    logic [OPW-1:0]      S_op;
    logic [DW-1:0]       S_opa;
    logic [DW-1:0]       S_opb;
    logic                S_ack;
    logic [DW-1:0]       S_result;
    logic [SELW-1:0]     Select;
    logic                busy;

    modport master (
        output M_req, M_op, M_opa, M_opb, S_ack, S_result,
        input  M_ack, M_err, M_result, S_req, S_op, S_opa, S_opb, Select, busy
    );

    modport slave (
        input  M_req, M_op, M_opa, M_opb, S_ack, S_result,
        output M_ack, M_err, M_result, S_req, S_op, S_opa, S_opb, Select, busy
    );
endinterface

// File: rtl/fpu_rr_scheduler.sv
// Round-robin arbiter sharing one FPU execution slave among NREQ requesters,
// with a req/ack slave handshake, four-phase result return and a timeout watchdog.
module fpu_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int SELW    = 2,
    parameter int DW      = 32,
    parameter int OPW     = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RSTn,
    fpu_rr_scheduler_if.slave bus
);
    localparam int CW = 16;
    localparam int IW = SELW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [SELW-1:0] ptr_r, ptr_s;
    logic [SELW-1:0] select_r, select_s;
    logic [SELW-1:0] win_s, sel_inc_s;
    logic            win_vld_s;
    logic [IW-1:0]   idx_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            s_req_r, s_req_s;
    logic            busy_r, busy_s;
    logic [OPW-1:0]  s_op_r, s_op_s;
    logic [DW-1:0]   s_opa_r, s_opa_s;
    logic [DW-1:0]   s_opb_r, s_opb_s;
    logic [DW-1:0]   m_result_r, m_result_s;
    logic [NREQ-1:0] m_ack_r, m_ack_s;
    logic [NREQ-1:0] m_err_r, m_err_s;
    logic [NREQ-1:0] onehot_s;

    // Round-robin search: offsets walked downward so the requester nearest above ptr wins last.
    always_comb begin
        win_s     = '0;
        win_vld_s = 1'b0;
        idx_s     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx_s     = {1'b0, ptr_r} + IW'(i);
            idx_s     = (idx_s >= IW'(NREQ)) ? (idx_s - IW'(NREQ)) : idx_s;
            win_s     = bus.M_req[idx_s[SELW-1:0]] ? idx_s[SELW-1:0] : win_s;
            win_vld_s = win_vld_s | bus.M_req[idx_s[SELW-1:0]];
        end
    end

    // Pointer successor of the granted index and its one-hot completion mask.
    always_comb begin
        sel_inc_s          = (select_r == SELW'(NREQ - 1)) ? '0 : (select_r + SELW'(1));
        onehot_s           = '0;
        onehot_s[select_r] = 1'b1;
    end

    // Next-state and next-output logic for the IDLE/ISSUE/DONE controller.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        select_s   = select_r;
        cnt_s      = cnt_r;
        s_req_s    = s_req_r;
        s_op_s     = s_op_r;
        s_opa_s    = s_opa_r;
        s_opb_s    = s_opb_r;
        m_result_s = m_result_r;
        m_ack_s    = m_ack_r;
        m_err_s    = m_err_r;
        case (state_r)
            IDLE: begin
                // A lingering S_ack belongs to the previous transaction; never grant over it.
                if (win_vld_s && !bus.S_ack) begin
                    select_s = win_s;
                    s_op_s   = bus.M_op[win_s*OPW +: OPW];
                    s_opa_s  = bus.M_opa[win_s*DW +: DW];
                    s_opb_s  = bus.M_opb[win_s*DW +: DW];
                    s_req_s  = 1'b1;
                    cnt_s    = '0;
                    state_s  = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (!bus.M_req[select_r]) begin
                    s_req_s = 1'b0;
                    ptr_s   = sel_inc_s;
                    state_s = IDLE;
                end else if (bus.S_ack) begin
                    s_req_s    = 1'b0;
                    m_result_s = bus.S_result;
                    m_ack_s    = onehot_s;
                    state_s    = DONE;
                end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                    s_req_s = 1'b0;
                    m_err_s = onehot_s;
                    state_s = DONE;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            DONE: begin
                if (!bus.M_req[select_r]) begin
                    m_ack_s = '0;
                    m_err_s = '0;
                    ptr_s   = sel_inc_s;
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                s_req_s = 1'b0;
                m_ack_s = '0;
                m_err_s = '0;
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers; reset drops S_req asynchronously.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r    <= IDLE;
            ptr_r      <= '0;
            select_r   <= '0;
            cnt_r      <= '0;
            s_req_r    <= 1'b0;
            busy_r     <= 1'b0;
            s_op_r     <= '0;
            s_opa_r    <= '0;
            s_opb_r    <= '0;
            m_result_r <= '0;
            m_ack_r    <= '0;
            m_err_r    <= '0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            select_r   <= select_s;
            cnt_r      <= cnt_s;
            s_req_r    <= s_req_s;
            busy_r     <= busy_s;
            s_op_r     <= s_op_s;
            s_opa_r    <= s_opa_s;
            s_opb_r    <= s_opb_s;
            m_result_r <= m_result_s;
            m_ack_r    <= m_ack_s;
            m_err_r    <= m_err_s;
        end
    end

    assign bus.S_req    = s_req_r;
    assign bus.S_op     = s_op_r;
    assign bus.S_opa    = s_opa_r;
    assign bus.S_opb    = s_opb_r;
    assign bus.M_ack    = m_ack_r;
    assign bus.M_err    = m_err_r;
    assign bus.M_result = m_result_r;
    assign bus.Select   = select_r;
    assign bus.busy     = busy_r;
endmodule

// File: doc/fpu_rr_scheduler.md
Name: fpu_rr_scheduler

Overview:
- Round-robin scheduler that shares one FPU execution slave among NREQ requesters (adder, multiplier, divider, convert units).
- Grants one requester at a time and latches that requester's operands and opcode.
- Drives the slave with a req/ack handshake and returns the result to the requester with a four-phase handshake.
- Has a timeout watchdog that errors out a hung slave. Sits between the requesting FPU units and the shared execution slave.

Parameters:
NREQ, 4, number of requesters (2..8)
SELW, 2, width of the grant index (must equal clog2(NREQ))
DW, 32, operand/result width
OPW, 4, opcode width
TIMEOUT, 255, maximum cycles in ISSUE waiting for S_ack (1..65535)

Ports:
CLK  input  1  clock, rising edge
RSTn  input  1  asynchronous active-low reset
M_req  input  NREQ  per-requester request, held until M_ack or M_err
M_op  input  NREQ*OPW  flattened opcodes; requester i uses bits [i*OPW +: OPW]
M_opa  input  NREQ*DW  flattened operand A
M_opb  input  NREQ*DW  flattened operand B
M_ack  output  NREQ  one-hot completion, held until the granted M_req falls
M_err  output  NREQ  one-hot timeout error, held until the granted M_req falls
M_result  output  DW  result captured from the slave, valid while M_ack is high
S_req  output  1  request to the shared slave
S_op  output  OPW  latched opcode
S_opa  output  DW  latched operand A
S_opb  output  DW  latched operand B
S_ack  input  1  slave completion
S_result  input  DW  slave result, valid with S_ack
Select  output  SELW  index of the current or last granted requester
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, CLK. RSTn is asynchronous and active-low. All outputs are registered.
- Reset values: state=IDLE, all outputs 0, rr pointer=0, timeout counter=0, operand latches=0.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - If any M_req bit is high and S_ack==0, pick the first set bit searching from the rr pointer upward, with wrap.
  - Latch the winner's op/opa/opb into S_op/S_opa/S_opb, set Select=winner, S_req=1, counter=0, and go to ISSUE.
  - Latency: M_req sampled at edge k gives S_req high after edge k.
  - If S_ack==1 in IDLE (stale ack from the previous transaction), no grant is made.
- ISSUE: checks are evaluated at each edge in priority order.
  - 1) M_req[Select]==0 (abort): S_req=0, no M_ack/M_err, rr pointer=Select+1 mod NREQ, go to IDLE. Abort wins over a simultaneous S_ack.
  - 2) S_ack==1: S_req=0, M_result=S_result, M_ack[Select]=1, go to DONE. S_ack wins over a simultaneous timeout.
  - 3) counter==TIMEOUT-1: S_req=0, M_err[Select]=1, go to DONE.
  - 4) Otherwise: counter+1, hold all outputs.
  - With no S_ack, M_err rises after exactly TIMEOUT cycles of S_req high.
- DONE:
  - Hold M_ack/M_err and M_result until M_req[Select] is sampled 0.
  - Then clear M_ack/M_err, set rr pointer=Select+1 mod NREQ, go to IDLE.
  - Requests from other requesters are ignored in DONE.
- Round-robin rules:
  - The pointer advances only on completion, abort or error, never on an idle cycle.
  - The granted index becomes lowest priority for the next arbitration.
  - Wrap: Select=NREQ-1 gives pointer 0.
- Operand latches change only on grant. Input operand changes during ISSUE do not reach S_op/S_opa/S_opb.
- At most one bit of M_ack|M_err is set at any time. M_ack and M_err are never high together.
- Reset mid-operation: everything returns to reset values immediately. The slave sees S_req fall asynchronously.
- The block produces no S_req-high edge without a fresh grant decision in IDLE.
- Requests while busy stay pending and are arbitrated on IDLE.

Test Plan:
- Single request: M_req=0001, opa=0x3F800000, opb=0x40000000, op=1; slave acks 3 cycles after S_req with S_result=0x40400000. Expect Select=0, S_opa/S_opb/S_op match, then M_ack=0001 and M_result=0x40400000 held until M_req drops; then IDLE, pointer=1.
- Fairness: M_req=1111 held, re-asserted one cycle after each drop, slave acks in 1 cycle. Expect grant order 0,1,2,3,0; each requester granted exactly twice in 8 transactions.
- Wrap plus lowest priority: pointer=3, M_req=1001. Expect grant 3, then grant 0 on the next arbitration.
- Timeout: TIMEOUT=8, M_req=0100, S_ack tied 0. Expect S_req high exactly 8 cycles, then M_err=0100 and M_ack=0, M_err held until M_req[2]=0.
- Abort and collisions:
  - M_req[1] dropped 2 cycles into ISSUE: expect S_req=0 next cycle, no ack/err, IDLE.
  - Abort and S_ack at the same edge: abort wins.
  - S_ack and timeout at the same edge: M_ack, not M_err.
- Reset: RSTn pulsed low while in DONE with M_ack=0010. Expect all outputs 0 immediately, pointer=0; after release, M_req=0011 grants requester 0.
